// File: rtl/card_detect_ctrl.sv
// SD card-detect controller: synchronizes the raw CD/WP pins, debounces insertion
// and removal, gates the downstream datapath and queues a single insert/remove event.
module card_detect_ctrl #(
    parameter int DB_LIMIT = 8,
    parameter int DB_CNT_W = 4
) (
    input  logic clk,
    input  logic n_rst,
    input  logic cd_n_async,
    input  logic wp_async,
    input  logic evt_ack,
    output logic card_present,
    output logic sd_en,
    output logic write_protect,
    output logic evt_valid,
    output logic evt_type,
    output logic evt_ovf
);

    typedef enum logic [1:0] {
        ST_ABSENT,
        ST_DB_IN,
        ST_PRESENT,
        ST_DB_OUT
    } state_t;

    // bit 0 = cd_n (idles high: no card), bit 1 = wp (idles low)
    localparam logic [1:0]          SYNC_RST = 2'b01;
    localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_LIMIT - 1);

    logic [1:0] w_async;
    logic [1:0] w_synced;
    logic       w_cd_n;
    logic       w_wp;

    assign w_async = {wp_async, cd_n_async};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic r_meta;
            logic r_sync;
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    r_meta <= SYNC_RST[gi];
                    r_sync <= SYNC_RST[gi];
                end else begin
                    r_meta <= w_async[gi];
                    r_sync <= r_meta;
                end
            end
            assign w_synced[gi] = r_sync;
        end
    endgenerate

    assign w_cd_n = w_synced[0];
    assign w_wp   = w_synced[1];

    state_t              r_state;
    state_t              w_state_next;
    logic [DB_CNT_W-1:0] r_cnt;
    logic [DB_CNT_W-1:0] w_cnt_next;
    logic                w_ins;
    logic                w_rem;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_ABSENT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_ins        = 1'b0;
        w_rem        = 1'b0;
        case (r_state)
            ST_ABSENT: begin
                if (!w_cd_n) begin
                    w_state_next = ST_DB_IN;
                    w_cnt_next   = '0;
                end
            end
            ST_DB_IN: begin
                if (w_cd_n) begin
                    w_state_next = ST_ABSENT;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = ST_PRESENT;
                    w_cnt_next   = '0;
                    w_ins        = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_PRESENT: begin
                if (w_cd_n) begin
                    w_state_next = ST_DB_OUT;
                    w_cnt_next   = '0;
                end
            end
            ST_DB_OUT: begin
                // a bounce back to "inserted" aborts the removal silently
                if (!w_cd_n) begin
                    w_state_next = ST_PRESENT;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = ST_ABSENT;
                    w_cnt_next   = '0;
                    w_rem        = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_ABSENT;
                w_cnt_next   = '0;
            end
        endcase
    end

    logic r_wp;
    logic r_evt_valid;
    logic r_evt_type;
    logic r_evt_ovf;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wp <= 1'b0;
        end else if (w_ins) begin
            r_wp <= w_wp;
        end else if (w_rem) begin
            r_wp <= 1'b0;
        end
    end

    // a fresh event always wins over an acknowledge landing on the same edge
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_evt_valid <= 1'b0;
            r_evt_type  <= 1'b0;
            r_evt_ovf   <= 1'b0;
        end else if (w_ins || w_rem) begin
            r_evt_valid <= 1'b1;
            r_evt_type  <= w_ins;
            if (r_evt_valid && !evt_ack) begin
                r_evt_ovf <= 1'b1;
            end
        end else if (r_evt_valid && evt_ack) begin
            r_evt_valid <= 1'b0;
            r_evt_ovf   <= 1'b0;
        end
    end

    assign card_present  = (r_state == ST_PRESENT) || (r_state == ST_DB_OUT);
    assign sd_en         = (r_state == ST_PRESENT);
    assign write_protect = r_wp;
    assign evt_valid     = r_evt_valid;
    assign evt_type      = r_evt_type;
    assign evt_ovf       = r_evt_ovf;

endmodule

// File: tb/tb_card_detect_ctrl.sv
// Bench for card_detect_ctrl: run-length behavioural model checked every cycle,
// plus directed literal checks at the edge counts of interest.
module tb_card_detect_ctrl;

    localparam int DB_LIMIT = 4;
    localparam int DB_CNT_W = 4;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic cd_n_async = 1'b1;
    logic wp_async = 1'b0;
    logic evt_ack = 1'b0;
    logic card_present, sd_en, write_protect, evt_valid, evt_type, evt_ovf;

    int tests = 0;
    int fails = 0;
    int cycle = 0;

    card_detect_ctrl #(.DB_LIMIT(DB_LIMIT), .DB_CNT_W(DB_CNT_W)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .cd_n_async   (cd_n_async),
        .wp_async     (wp_async),
        .evt_ack      (evt_ack),
        .card_present (card_present),
        .sd_en        (sd_en),
        .write_protect(write_protect),
        .evt_valid    (evt_valid),
        .evt_type     (evt_type),
        .evt_ovf      (evt_ovf)
    );

    always #5 clk = ~clk;

    // Model: the pins reach the debouncer two edges late; the card flips state once
    // DB_LIMIT+1 consecutive samples disagree with the current state.
    int m_run;
    bit m_present, m_wp, m_v, m_t, m_o;
    bit m_cd1, m_cd2, m_wp1, m_wp2;
    bit m_x, m_wx, m_ins, m_rem, m_home;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_run = 0; m_present = 0; m_wp = 0; m_v = 0; m_t = 0; m_o = 0;
            m_cd1 = 1; m_cd2 = 1; m_wp1 = 0; m_wp2 = 0;
        end else begin
            m_x = m_cd2; m_wx = m_wp2;
            m_cd2 = m_cd1; m_cd1 = cd_n_async;
            m_wp2 = m_wp1; m_wp1 = wp_async;
            m_ins = 0; m_rem = 0;
            m_home = !m_present;
            if (m_x != m_home) m_run = m_run + 1;
            else m_run = 0;
            if (m_run == DB_LIMIT + 1) begin
                m_run = 0;
                m_present = !m_present;
                m_ins = m_present;
                m_rem = !m_present;
                m_wp = m_ins ? m_wx : 1'b0;
            end
            if (m_ins || m_rem) begin
                if (m_v && !evt_ack) m_o = 1;
                m_v = 1;
                m_t = m_ins;
            end else if (m_v && evt_ack) begin
                m_v = 0;
                m_o = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [5:0] act, exp;
        cycle++;
        act = {card_present, sd_en, write_protect, evt_valid, evt_type, evt_ovf};
        exp = {m_present, m_present && (m_run == 0), m_wp, m_v, m_t, m_o};
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL model cycle %0d {cp,sd_en,wp,ev,et,ovf} got %b expected %b",
                     cycle, act, exp);
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %b expected %b", name, act, exp);
        end else begin
            $display("[TB] ok %s = %b", name, act);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic ack_pulse();
        evt_ack = 1'b1;
        step(1);
        evt_ack = 1'b0;
    endtask

    initial begin
        step(3);
        chk("reset card_present", card_present, 1'b0);
        chk("reset sd_en", sd_en, 1'b0);
        chk("reset evt_valid", evt_valid, 1'b0);
        n_rst = 1'b1;
        step(2);

        // glitch shorter than the debounce window
        cd_n_async = 1'b0;
        step(3);
        cd_n_async = 1'b1;
        step(10);
        chk("glitch card_present", card_present, 1'b0);
        chk("glitch evt_valid", evt_valid, 1'b0);

        // insertion with write-protect set
        cd_n_async = 1'b0; wp_async = 1'b1;
        step(6);
        chk("ins edge6 card_present", card_present, 1'b0);
        step(1);
        chk("ins edge7 card_present", card_present, 1'b1);
        chk("ins edge7 sd_en", sd_en, 1'b1);
        chk("ins edge7 write_protect", write_protect, 1'b1);
        chk("ins edge7 evt_valid", evt_valid, 1'b1);
        chk("ins edge7 evt_type", evt_type, 1'b1);
        ack_pulse();
        chk("ack clears evt_valid", evt_valid, 1'b0);
        ack_pulse();
        chk("idle ack evt_valid", evt_valid, 1'b0);

        // removal: fast sd_en drop, then event after the full window
        cd_n_async = 1'b1;
        step(3);
        chk("rem edge3 sd_en", sd_en, 1'b0);
        chk("rem edge3 card_present", card_present, 1'b1);
        step(4);
        chk("rem edge7 card_present", card_present, 1'b0);
        chk("rem edge7 evt_valid", evt_valid, 1'b1);
        chk("rem edge7 evt_type", evt_type, 1'b0);
        chk("rem edge7 write_protect", write_protect, 1'b0);
        ack_pulse();

        // overwrite of an unacknowledged insert event
        cd_n_async = 1'b0; wp_async = 1'b0;
        step(7);
        cd_n_async = 1'b1;
        step(7);
        chk("ovf evt_valid", evt_valid, 1'b1);
        chk("ovf evt_type", evt_type, 1'b0);
        chk("ovf evt_ovf", evt_ovf, 1'b1);
        ack_pulse();
        chk("ovf ack evt_valid", evt_valid, 1'b0);
        chk("ovf ack evt_ovf", evt_ovf, 1'b0);

        // removal completes on the same edge as the insert acknowledge
        cd_n_async = 1'b0;
        step(7);
        cd_n_async = 1'b1;
        step(6);
        evt_ack = 1'b1;
        step(1);
        evt_ack = 1'b0;
        chk("coinc evt_valid", evt_valid, 1'b1);
        chk("coinc evt_type", evt_type, 1'b0);
        chk("coinc evt_ovf", evt_ovf, 1'b0);
        ack_pulse();

        // reset in the middle of DB_OUT
        cd_n_async = 1'b0; wp_async = 1'b1;
        step(7);
        ack_pulse();
        cd_n_async = 1'b1;
        step(4);
        chk("pre-rst card_present", card_present, 1'b1);
        n_rst = 1'b0;
        #1;
        chk("async rst card_present", card_present, 1'b0);
        chk("async rst write_protect", write_protect, 1'b0);
        chk("async rst sd_en", sd_en, 1'b0);
        step(1);
        n_rst = 1'b1;
        step(3);
        chk("post-rst card_present", card_present, 1'b0);

        // card already inserted while reset is released
        n_rst = 1'b0; cd_n_async = 1'b0; wp_async = 1'b0;
        step(2);
        n_rst = 1'b1;
        step(6);
        chk("rst-ins edge6 card_present", card_present, 1'b0);
        step(1);
        chk("rst-ins edge7 card_present", card_present, 1'b1);
        chk("rst-ins evt_type", evt_type, 1'b1);
        chk("rst-ins write_protect", write_protect, 1'b0);
        ack_pulse();

        // short removal bounce returns to PRESENT with no event
        cd_n_async = 1'b1;
        step(2);
        cd_n_async = 1'b0;
        step(10);
        chk("bounce card_present", card_present, 1'b1);
        chk("bounce sd_en", sd_en, 1'b1);
        chk("bounce evt_valid", evt_valid, 1'b0);

        step(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/card_detect_ctrl.md
CARD_DETECT_CTRL -- requirements
Module: card_detect_ctrl

Interface
REQ-001 Parameter DB_LIMIT, default 8, required consecutive stable cycles for debounce; legal range 2..2^DB_CNT_W.
REQ-002 Parameter DB_CNT_W, default 4, debounce counter width in bits.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 n_rst  input  1  asynchronous active-low reset; one clock, reset is asynchronous and active-low.
REQ-005 cd_n_async  input  1  raw SD card-detect pin, asynchronous; 0 = card inserted.
REQ-006 wp_async  input  1  raw SD write-protect pin, asynchronous; 1 = protected.
REQ-007 evt_ack  input  1  host acknowledge of pending event.
REQ-008 card_present  output  1  debounced card presence.
REQ-009 sd_en  output  1  enable for downstream SD/AES datapath.
REQ-010 write_protect  output  1  write-protect state latched at insertion.
REQ-011 evt_valid  output  1  insert/remove event pending.
REQ-012 evt_type  output  1  1 = insert, 0 = remove; meaningful only while evt_valid=1.
REQ-013 evt_ovf  output  1  sticky flag: an unacknowledged event was overwritten.

Function
REQ-014 Each async input shall pass through a two-flop synchronizer inside the block; cd_n flops reset to 1 (absent), wp flops reset to 0.
REQ-015 FSM states shall be ABSENT, DB_IN, PRESENT, DB_OUT, with a DB_CNT_W-bit counter cnt.
REQ-016 ABSENT: synced cd_n=0 -> DB_IN with cnt=0; otherwise stay.
REQ-017 DB_IN: synced cd_n=1 -> ABSENT with cnt=0; cd_n=0 and cnt=DB_LIMIT-1 -> PRESENT; else cnt+1.
REQ-018 PRESENT: synced cd_n=1 -> DB_OUT with cnt=0; otherwise stay.
REQ-019 DB_OUT: synced cd_n=0 -> PRESENT with cnt=0, no event; cd_n=1 and cnt=DB_LIMIT-1 -> ABSENT; else cnt+1.
REQ-020 Total latency from async edge to state change shall be DB_LIMIT+3 rising edges when input held stable.
REQ-021 card_present shall be 1 in PRESENT and DB_OUT, 0 otherwise.
REQ-022 sd_en shall be 1 only in PRESENT, so it drops on the first cycle of DB_OUT (fast shutdown).
REQ-023 write_protect shall load synced wp on the DB_IN->PRESENT transition, hold through PRESENT/DB_OUT, and clear to 0 on entry to ABSENT.
REQ-024 DB_IN->PRESENT shall raise evt_valid with evt_type=1 on the next cycle; DB_OUT->ABSENT shall raise evt_valid with evt_type=0.
REQ-025 evt_valid shall stay 1 until evt_ack is sampled high while evt_valid=1, then clear on that edge.
REQ-026 evt_ack while evt_valid=0 shall have no effect.
REQ-027 New event while evt_valid=1 and evt_ack=0: evt_type is overwritten, evt_valid stays 1, evt_ovf sets to 1.
REQ-028 New event coinciding with evt_ack: new event wins (evt_valid stays 1, new evt_type), evt_ovf unchanged.
REQ-029 evt_ovf shall clear on any accepted evt_ack with no coincident new event.
REQ-030 cnt shall never exceed DB_LIMIT-1; no wrap-around shall occur.

Reset
REQ-031 Asserting n_rst low shall immediately force state ABSENT, cnt=0, all sync flops to reset values, and all outputs to 0, regardless of current state.
REQ-032 After n_rst deasserts with card already inserted, insertion shall be detected as a normal DB_LIMIT+3-edge sequence with an insert event.

Verification
REQ-033 DB_LIMIT=4, cd_n_async 1->0 held, wp_async=1 -> card_present, sd_en, write_protect =1 after edge 7; evt_valid=1, evt_type=1 same cycle.
REQ-034 Glitch: from ABSENT, cd_n_async low for 3 cycles then high -> card_present stays 0, evt_valid stays 0.
REQ-035 From PRESENT, cd_n_async 0->1 held -> sd_en=0 after edge 3, card_present=0 and evt_valid=1, evt_type=0 after edge 7.
REQ-036 Insert event unacked, then removal completes -> evt_valid=1, evt_type=0, evt_ovf=1; evt_ack pulse -> evt_valid=0, evt_ovf=0 next edge.
REQ-037 n_rst pulsed low mid-DB_OUT -> all outputs 0 asynchronously; state ABSENT after release.
REQ-038 Removal event completing on same edge as evt_ack of pending insert -> evt_valid=1, evt_type=0, evt_ovf=0.
